// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: accepts a (direction, detents, period) command
// and walks a registered Gray-coded A/B pair one edge every `period` clocks.
module quad_encoder_gen #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
    localparam logic [CNT_W+1:0] ONE_E = (CNT_W + 2)'(1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] period_q, period_nxt;
    logic [DIV_W-1:0] timer_q, timer_nxt;
    logic [CNT_W+1:0] edge_q, edge_nxt;
    logic             dir_q, dir_nxt;
    logic             a_q, a_nxt;
    logic             b_q, b_nxt;
    logic             done_q, done_nxt;
    logic [DIV_W-1:0] eff_period;

    assign eff_period = (cmd_period == '0) ? ONE_D : cmd_period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            period_q <= '0;
            timer_q  <= '0;
            edge_q   <= '0;
            dir_q    <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            period_q <= period_nxt;
            timer_q  <= timer_nxt;
            edge_q   <= edge_nxt;
            dir_q    <= dir_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        period_nxt = period_q;
        timer_nxt  = timer_q;
        edge_nxt   = edge_q;
        dir_nxt    = dir_q;
        a_nxt      = a_q;
        b_nxt      = b_q;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    dir_nxt    = cmd_dir;
                    period_nxt = eff_period;
                    timer_nxt  = eff_period - ONE_D;
                    edge_nxt   = {cmd_steps, 2'b00};
                    if (cmd_steps == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    edge_nxt  = '0;
                end else if (timer_q == '0) begin
                    // CW: 00->10->11->01, CCW: 00->01->11->10 (one bit flips per edge)
                    a_nxt     = dir_q ? ~b_q : b_q;
                    b_nxt     = dir_q ? a_q : ~a_q;
                    edge_nxt  = edge_q - ONE_E;
                    timer_nxt = period_q - ONE_D;
                    if (edge_q == ONE_E) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        timer_nxt = '0;
                    end
                end else begin
                    timer_nxt = timer_q - ONE_D;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enc_a     = a_q;
    assign enc_b     = b_q;
    assign done      = done_q;
    assign busy      = (state == RUN);
    assign cmd_ready = (state == IDLE);

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: walks the command, abort, back-to-back
// and reset scenarios, checking A/B, done, busy and cmd_ready each clock.
module tb_quad_encoder_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        enc_a, enc_b, busy, done;

    int checks = 0;
    int failures = 0;
    logic [1:0] model_ab = 2'b00;
    int last_net = 0;

    quad_encoder_gen #(.CNT_W(8), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Table-driven reference of the Gray sequence, indexed in CW order
    function automatic logic [1:0] nextAb(input logic [1:0] ab, input logic dir);
        logic [1:0] tab [4];
        int idx;
        tab = '{2'b00, 2'b10, 2'b11, 2'b01};
        idx = 0;
        for (int i = 0; i < 4; i++) if (tab[i] == ab) idx = i;
        idx = dir ? (idx + 1) % 4 : (idx + 3) % 4;
        return tab[idx];
    endfunction

    // Issue one command and check every clock until completion (or abort after abort_at edges)
    task automatic applyStimulus(input logic dir, input logic [7:0] steps, input logic [15:0] period,
                                 input int abort_at, input string tag);
        int p, total, edges;
        logic abort_armed;
        p = (period == 0) ? 1 : int'(period);
        total = 4 * int'(steps) * p;
        edges = 0;
        last_net = 0;
        abort_armed = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = steps; cmd_period = period;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int m = 1; m <= total; m++) begin
            @(posedge clk); #1;
            if (abort_armed) begin
                abort = 1'b0;
                checkOutput({tag, "_abort_ab"}, {enc_a, enc_b}, model_ab);
                checkOutput({tag, "_abort_busy"}, busy, 0);
                checkOutput({tag, "_abort_ready"}, cmd_ready, 1);
                checkOutput({tag, "_abort_done"}, done, 0);
                repeat (4) @(posedge clk);
                #1;
                checkOutput({tag, "_abort_frozen"}, {enc_a, enc_b}, model_ab);
                checkOutput({tag, "_abort_nodone"}, done, 0);
                return;
            end
            if (m % p == 0) begin
                last_net += (nextAb(model_ab, 1'b1) == nextAb(model_ab, dir) && dir) ? 1 : -1;
                model_ab = nextAb(model_ab, dir);
                edges++;
            end
            checkOutput({tag, "_ab"}, {enc_a, enc_b}, model_ab);
            checkOutput({tag, "_done"}, done, (m == total) ? 1 : 0);
            checkOutput({tag, "_busy"}, busy, (m == total) ? 0 : 1);
            if (abort_at >= 0 && edges == abort_at && m % p == 0) begin
                abort = 1'b1;
                abort_armed = 1'b1;
            end
        end
        @(posedge clk); #1;
        checkOutput({tag, "_done_single"}, done, 0);
        checkOutput({tag, "_ready_after"}, cmd_ready, 1);
    endtask

    initial begin
        int activity;
        int done_count;

        // Reset and idle quiet period
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ab", {enc_a, enc_b}, 2'b00);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if ({enc_a, enc_b} != 2'b00 || done || busy || !cmd_ready) activity++;
        end
        checkOutput("idle_quiet", activity, 0);

        applyStimulus(1'b1, 8'd1, 16'd3, -1, "cw1p3");
        checkOutput("cw1p3_final", {enc_a, enc_b}, 2'b00);

        applyStimulus(1'b0, 8'd2, 16'd0, -1, "ccw2p0");
        checkOutput("ccw2p0_final", {enc_a, enc_b}, 2'b00);
        checkOutput("ccw2p0_detents", last_net / 4, -2);

        // Zero-step command: immediate done, no motion, never busy
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd0; cmd_period = 16'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_ready", cmd_ready, 1);
        @(posedge clk); #1;
        checkOutput("zero_done_off", done, 0);
        checkOutput("zero_ab", {enc_a, enc_b}, 2'b00);

        applyStimulus(1'b1, 8'd5, 16'd2, 6, "abort");
        checkOutput("abort_at11", {enc_a, enc_b}, 2'b11);
        applyStimulus(1'b1, 8'd1, 16'd2, -1, "post_abort");
        checkOutput("post_abort_final", {enc_a, enc_b}, 2'b11);

        // Return to 00 with a partial CW run aborted after one edge
        applyStimulus(1'b1, 8'd1, 16'd1, 1, "realign");
        checkOutput("realign_ab", {enc_a, enc_b}, 2'b01);
        applyStimulus(1'b1, 8'd1, 16'd1, 1, "realign2");
        checkOutput("realign2_ab", {enc_a, enc_b}, 2'b00);
        model_ab = 2'b00;

        // Back-to-back: CW 1 step then CCW 1 step with cmd_valid held high
        done_count = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd1; cmd_period = 16'd1;
        @(posedge clk); #1;
        cmd_dir = 1'b0;
        for (int m = 1; m <= 10; m++) begin
            @(posedge clk); #1;
            if (done) done_count++;
            if (m == 4) begin
                checkOutput("b2b_first_ab", {enc_a, enc_b}, 2'b00);
                checkOutput("b2b_first_ready", cmd_ready, 1);
            end
            if (m == 5) begin
                cmd_valid = 1'b0;
                checkOutput("b2b_second_busy", busy, 1);
                checkOutput("b2b_second_ab", {enc_a, enc_b}, 2'b00);
            end
            if (m == 6) checkOutput("b2b_ccw_first", {enc_a, enc_b}, 2'b01);
            if (m == 9) checkOutput("b2b_second_done", done, 1);
        end
        checkOutput("b2b_done_count", done_count, 2);
        checkOutput("b2b_final_ab", {enc_a, enc_b}, 2'b00);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd5; cmd_period = 16'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mid_run_ab", {enc_a, enc_b}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ab", {enc_a, enc_b}, 2'b00);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_ready", cmd_ready, 1);
        checkOutput("async_rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy || {enc_a, enc_b} != 2'b00) activity++;
        end
        checkOutput("post_rst_quiet", activity, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_encoder_gen.md
# quad_encoder_gen

Quadrature encoder emulator: the transmitting end of the rotary-encoder interface that the countdown timer decodes on its `enc*_a`/`enc*_b` inputs. Takes a command (direction, detent count, phase period) over a valid/ready handshake and drives a Gray-coded A/B pair with one quadrature edge every `period` clocks. Used on-chip as a self-test source feeding the encoder decoders, and as a reusable stimulus block.

## Interface
Parameters:
- `CNT_W`, 8: width of the detent count in a command.
- `DIV_W`, 16: width of the phase period (clocks per quadrature edge).

Ports:
- `clk` in 1: single system clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block can accept a command (high only in IDLE).
- `cmd_dir` in 1: 1 = CW (A leads B), 0 = CCW (B leads A).
- `cmd_steps` in CNT_W: number of detents; one detent is 4 quadrature edges.
- `cmd_period` in DIV_W: clocks between edges; 0 is treated as 1.
- `abort` in 1: stop the current command.
- `enc_a`, `enc_b` out 1 each: quadrature outputs, registered, glitch-free.
- `busy` out 1: command in progress (RUN state).
- `done` out 1: single-cycle pulse on normal completion.

## Operation
- State machine: IDLE, RUN.
- IDLE: `cmd_ready`=1, `busy`=0. On `cmd_valid`&`cmd_ready` at a rising edge, latch dir, period (0→1), load edge counter = 4·`cmd_steps` (CNT_W+2 bits, no overflow), load timer = period−1.
  - If `cmd_steps`=0: stay IDLE, pulse `done` the next cycle, no edge on A/B.
  - Otherwise go to RUN.
- RUN: timer decrements each clock. At timer=0: advance phase by one Gray step, decrement edge counter, reload timer = period−1.
  - When the edge counter reaches 0: return to IDLE and pulse `done`.
- Phase sequence (A,B): CW 00→10→11→01→00. CCW 00→01→11→10→00. Exactly one of A/B changes per edge.
- The phase register persists between commands. Every whole command returns A/B to the phase it started from.
- `abort`:
  - In RUN: go to IDLE at the next edge. Phase frozen at its current value, possibly mid-detent. No `done`. Counters cleared.
  - In IDLE: ignored. If `abort` and an accepted command coincide in IDLE, the command is taken.
- `cmd_*` inputs are ignored when `cmd_ready`=0.

## Timing
- Reset values: `enc_a`=0, `enc_b`=0, `busy`=0, `done`=0, `cmd_ready`=1, state IDLE. All counters 0.
- Reset asserted mid-RUN clears everything immediately (asynchronous). No `done` is produced.
- Command accepted at edge k, with P = effective period:
  - First A/B change visible after edge k+P.
  - n-th change after edge k+n·P.
  - Last change after edge k+4·steps·P.
- At the edge of the last change: `busy` falls, `cmd_ready` rises, `done`=1 for exactly one cycle. The next command can be accepted at the following edge (back-to-back; gap between edges ≥ P+1 clocks).
- `busy` rises at the edge after acceptance: high from edge k to the final edge.
- steps=0: `done` high in the cycle after edge k. `cmd_ready` stays high.
- Abort sampled at edge j: no A/B change at edge j or later. `cmd_ready`=1 after edge j.

## Test plan
- Reset: hold `rst_n`=0, then release → A/B=00, `busy`=0, `cmd_ready`=1, `done`=0; no activity for 50 clocks.
- CW, steps=1, period=3 → A/B 10,11,01,00 appear 3, 6, 9, 12 clocks after acceptance. `done` is a single pulse at clock 12 and `busy` falls at the same edge.
- CCW, steps=2, period=0 (treated as 1) → A/B 01,11,10,00,01,11,10,00 on consecutive clocks, then `done`. A decoder instance counts −2 detents.
- steps=0 → no A/B edge, `done` one cycle after acceptance, `busy` never high.
- Abort after 6 edges of a CW 5-step command (period=2) → A/B frozen at 11, no `done`. A following CW 1-step command starts from 11 and goes 01,00,10,11.
- Back-to-back CW 1-step then CCW 1-step with `cmd_valid` held high → second command accepted at the edge after the first `done`. Final A/B=00, two `done` pulses. Async reset mid-RUN → outputs return to reset values immediately.
